// File: rtl/i2s_ctrl_pkg.sv
// Shared types and constants for the I2S microphone capture sequencer.
package i2s_ctrl_pkg;
   localparam int SLOT_BITS = 32;
   localparam int SAMPLE_W  = 24;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STARTUP = 3'd1,
      ST_DISCARD = 3'd2,
      ST_RUN     = 3'd3,
      ST_STOP    = 3'd4
   } state_e;
endpackage

// File: rtl/i2s_sck_ws_gen.sv
// SCK/WS generator: divides clk_i into SCK, counts slot bits, flags the end of each right slot.
module i2s_sck_ws_gen
   import i2s_ctrl_pkg::*;
#(
   parameter int SCK_HALF = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic run,
   output logic sck,
   output logic ws,
   output logic frame_end
);
   localparam int DIV_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
   localparam int BIT_W = $clog2(SLOT_BITS);

   logic [DIV_W-1:0] div_q;
   logic [BIT_W-1:0] bit_q;
   logic             sck_q;
   logic             ws_q;
   logic             div_tc;
   logic             last_bit;

   assign div_tc    = (div_q == DIV_W'(SCK_HALF - 1));
   assign last_bit  = (bit_q == BIT_W'(SLOT_BITS - 1));
   // A falling toggle on the last bit of the right slot closes a stereo frame.
   assign frame_end = run && div_tc && sck_q && last_bit && ws_q;
   assign sck       = sck_q;
   assign ws        = ws_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= '0;
         bit_q <= '0;
         sck_q <= 1'b0;
         ws_q  <= 1'b0;
      end else if (!run) begin
         div_q <= '0;
         bit_q <= '0;
         sck_q <= 1'b0;
         ws_q  <= 1'b0;
      end else if (div_tc) begin
         div_q <= '0;
         sck_q <= ~sck_q;
         if (sck_q) begin
            bit_q <= bit_q + 1'b1;
            if (last_bit) ws_q <= ~ws_q;
         end
      end else begin
         div_q <= div_q + 1'b1;
      end
   end
endmodule

// File: rtl/i2s_mic_ctrl.sv
// Microphone capture sequencer: power-up timing, frame discard, and a one-entry output stream buffer.
module i2s_mic_ctrl
   import i2s_ctrl_pkg::*;
#(
   parameter int SCK_HALF       = 4,
   parameter int STARTUP_CYCLES = 1000000,
   parameter int DISCARD_FRAMES = 4,
   parameter int FCNT_W         = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                enable_i,
   input  logic                clear_ovf_i,
   output logic                sck_o,
   output logic                ws_o,
   output logic                cap_rst_no,
   input  logic [SAMPLE_W-1:0] cap_left_i,
   input  logic [SAMPLE_W-1:0] cap_right_i,
   input  logic                cap_ready_i,
   output logic [SAMPLE_W-1:0] out_left_o,
   output logic [SAMPLE_W-1:0] out_right_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                overflow_o,
   output logic [2:0]          state_o,
   output logic [FCNT_W-1:0]   frame_cnt_o
);
   state_e      state_q;
   logic [31:0] su_cnt_q;
   logic [31:0] disc_cnt_q;
   logic        frame_end;
   logic        can_load;

   i2s_sck_ws_gen #(.SCK_HALF(SCK_HALF)) u_gen (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .run       (state_q != ST_IDLE),
      .sck       (sck_o),
      .ws        (ws_o),
      .frame_end (frame_end)
   );

   assign state_o = state_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         cap_rst_no <= 1'b0;
         su_cnt_q   <= '0;
         disc_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable_i) begin
                  state_q    <= ST_STARTUP;
                  cap_rst_no <= 1'b1;
                  su_cnt_q   <= '0;
               end
            end
            ST_STARTUP: begin
               if (!enable_i) begin
                  state_q    <= ST_IDLE;
                  cap_rst_no <= 1'b0;
               end else if (su_cnt_q == 32'(STARTUP_CYCLES - 1)) begin
                  disc_cnt_q <= '0;
                  state_q    <= (DISCARD_FRAMES == 0) ? ST_RUN : ST_DISCARD;
               end else begin
                  su_cnt_q <= su_cnt_q + 1'b1;
               end
            end
            ST_DISCARD: begin
               if (!enable_i) begin
                  state_q <= ST_STOP;
               end else if (cap_ready_i) begin
                  if (disc_cnt_q == 32'(DISCARD_FRAMES - 1)) state_q <= ST_RUN;
                  else disc_cnt_q <= disc_cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (!enable_i) state_q <= ST_STOP;
            end
            ST_STOP: begin
               // Always finish the current right slot, even if enable_i comes back.
               if (frame_end) begin
                  state_q    <= ST_IDLE;
                  cap_rst_no <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               cap_rst_no <= 1'b0;
            end
         endcase
      end
   end

   // Stream: a beat transfers on a cycle with out_valid_o && out_ready_i; while
   // out_valid_o is high and out_ready_i low, data holds and valid stays up.
   assign can_load = !out_valid_o || out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_left_o  <= '0;
         out_right_o <= '0;
         out_valid_o <= 1'b0;
         overflow_o  <= 1'b0;
         frame_cnt_o <= '0;
      end else begin
         if (state_q == ST_RUN && cap_ready_i && can_load) begin
            out_left_o  <= cap_left_i;
            out_right_o <= cap_right_i;
            out_valid_o <= 1'b1;
            frame_cnt_o <= frame_cnt_o + 1'b1;
         end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
         end
         if (state_q == ST_RUN && cap_ready_i && !can_load) overflow_o <= 1'b1;
         else if (clear_ovf_i) overflow_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_i2s_mic_ctrl.sv
// Directed bench for i2s_mic_ctrl with a frame-level capture-stage model driven off ws_o.
module tb_i2s_mic_ctrl;
   localparam int FCNT_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic              clear_ovf;
   logic              sck;
   logic              ws;
   logic              cap_rst_n;
   logic [23:0]       cap_left;
   logic [23:0]       cap_right;
   logic              cap_ready;
   logic [23:0]       out_left;
   logic [23:0]       out_right;
   logic              out_valid;
   logic              out_ready;
   logic              overflow;
   logic [2:0]        state;
   logic [FCNT_W-1:0] frame_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   i2s_mic_ctrl #(
      .SCK_HALF(2), .STARTUP_CYCLES(100), .DISCARD_FRAMES(2), .FCNT_W(FCNT_W)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .enable_i    (enable),
      .clear_ovf_i (clear_ovf),
      .sck_o       (sck),
      .ws_o        (ws),
      .cap_rst_no  (cap_rst_n),
      .cap_left_i  (cap_left),
      .cap_right_i (cap_right),
      .cap_ready_i (cap_ready),
      .out_left_o  (out_left),
      .out_right_o (out_right),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .overflow_o  (overflow),
      .state_o     (state),
      .frame_cnt_o (frame_cnt)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Capture model: one cap_ready pulse per frame, issued right after ws falls.
   task automatic mic_frame(input int n, input logic clr, input logic rdy);
      logic prev;
      bit   found;
      prev  = ws;
      found = 0;
      for (int t = 0; t < 600 && !found; t++) begin
         tick(1);
         if (prev && !ws) found = 1;
         else prev = ws;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL mic_frame_timeout n=%0d ws_fall_seen=%0d required=1", n, found);
      end
      cap_left  = 24'(n);
      cap_right = 24'h800000 | 24'(n);
      cap_ready = 1'b1;
      clear_ovf = clr;
      out_ready = rdy;
      tick(1);
      cap_ready = 1'b0;
      clear_ovf = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; clear_ovf = 1'b0; cap_ready = 1'b0;
      out_ready = 1'b0; cap_left = '0; cap_right = '0;
      tick(3);
      rst_n = 1'b1;
      for (int i = 0; i < 500; i++) begin
         tick(1);
         checks++;
         if ({sck, ws, cap_rst_n, out_valid, overflow} !== 5'b0 || state !== 3'd0 || frame_cnt !== '0) begin
            failures++;
            $display("FAIL idle_hold cyc=%0d sck=%b ws=%b cap_rst_n=%b valid=%b ovf=%b state=%0d cnt=%0d required all 0",
                     i, sck, ws, cap_rst_n, out_valid, overflow, state, frame_cnt);
         end
      end
   endtask

   task automatic test_startup();
      logic [5:0] sck_tab;
      logic       exp_b;
      logic [2:0] exp_s;
      sck_tab = 6'b100110;  // bit (k-2) = expected sck for k=2..7
      enable = 1'b1;
      tick(1);
      checks++;
      if (cap_rst_n !== 1'b1 || state !== 3'd1 || sck !== 1'b0) begin
         failures++;
         $display("FAIL startup_entry cap_rst_n=%b state=%0d sck=%b required 1/1/0", cap_rst_n, state, sck);
      end
      for (int k = 2; k <= 130; k++) begin
         tick(1);
         if (k <= 7) begin
            exp_b = sck_tab[k-2];
            checks++;
            if (sck !== exp_b) begin
               failures++;
               $display("FAIL sck_wave k=%0d sck=%b required=%b", k, sck, exp_b);
            end
         end
         if (k == 128 || k == 129) begin
            exp_b = (k == 129);
            checks++;
            if (ws !== exp_b) begin
               failures++;
               $display("FAIL ws_toggle k=%0d ws=%b required=%b", k, ws, exp_b);
            end
         end
         if (k == 100 || k == 101) begin
            exp_s = (k == 100) ? 3'd1 : 3'd2;
            checks++;
            if (state !== exp_s) begin
               failures++;
               $display("FAIL startup_len k=%0d state=%0d required=%0d", k, state, exp_s);
            end
         end
      end
   endtask

   task automatic test_discard_run();
      mic_frame(1, 1'b0, 1'b0);
      checks++;
      if (state !== 3'd2 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL discard_first state=%0d valid=%b required 2/0", state, out_valid);
      end
      mic_frame(2, 1'b0, 1'b0);
      checks++;
      if (state !== 3'd3 || out_valid !== 1'b0 || frame_cnt !== 16'd0) begin
         failures++;
         $display("FAIL discard_last state=%0d valid=%b cnt=%0d required 3/0/0", state, out_valid, frame_cnt);
      end
      mic_frame(3, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_left !== 24'h000003 || out_right !== 24'h800003 || frame_cnt !== 16'd1) begin
         failures++;
         $display("FAIL first_frame valid=%b L=%h R=%h cnt=%0d required 1/000003/800003/1",
                  out_valid, out_left, out_right, frame_cnt);
      end
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL handshake_drop valid=%b required=0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      mic_frame(4, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_left !== 24'd4 || frame_cnt !== 16'd2 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL bp_load valid=%b L=%h cnt=%0d ovf=%b required 1/000004/2/0", out_valid, out_left, frame_cnt, overflow);
      end
      mic_frame(5, 1'b0, 1'b0);
      checks++;
      if (overflow !== 1'b1 || out_left !== 24'd4 || out_right !== 24'h800004 || frame_cnt !== 16'd2) begin
         failures++;
         $display("FAIL bp_drop ovf=%b L=%h R=%h cnt=%0d required 1/000004/800004/2", overflow, out_left, out_right, frame_cnt);
      end
      mic_frame(6, 1'b1, 1'b0);
      checks++;
      if (overflow !== 1'b1 || out_left !== 24'd4) begin
         failures++;
         $display("FAIL ovf_set_wins ovf=%b L=%h required 1/000004", overflow, out_left);
      end
      clear_ovf = 1'b1;
      tick(1);
      clear_ovf = 1'b0;
      checks++;
      if (overflow !== 1'b0 || out_valid !== 1'b1 || out_left !== 24'd4) begin
         failures++;
         $display("FAIL ovf_clear ovf=%b valid=%b L=%h required 0/1/000004", overflow, out_valid, out_left);
      end
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_drain valid=%b required=0", out_valid);
      end
   endtask

   task automatic test_simultaneous();
      mic_frame(7, 1'b0, 1'b0);
      mic_frame(8, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_left !== 24'd8 || out_right !== 24'h800008 || frame_cnt !== 16'd4 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL simul_load valid=%b L=%h R=%h cnt=%0d ovf=%b required 1/000008/800008/4/0",
                  out_valid, out_left, out_right, frame_cnt, overflow);
      end
   endtask

   task automatic test_stop();
      int   j_idle;
      logic ws_before;
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      mic_frame(9, 1'b0, 1'b0);
      tick(40);
      enable = 1'b0;
      tick(1);
      checks++;
      if (state !== 3'd4 || sck === 1'bx) begin
         failures++;
         $display("FAIL stop_entry state=%0d required=4", state);
      end
      j_idle    = -1;
      ws_before = 1'b0;
      for (int j = 1; j <= 400 && j_idle < 0; j++) begin
         ws_before = ws;
         tick(1);
         if (state === 3'd0) j_idle = j;
      end
      checks++;
      if (j_idle != 214 || ws_before !== 1'b1) begin
         failures++;
         $display("FAIL stop_frame_end cycles=%0d ws_before=%b required 214/1", j_idle, ws_before);
      end
      checks++;
      if (cap_rst_n !== 1'b0 || sck !== 1'b0 || ws !== 1'b0) begin
         failures++;
         $display("FAIL stop_idle cap_rst_n=%b sck=%b ws=%b required 0/0/0", cap_rst_n, sck, ws);
      end
      checks++;
      if (out_valid !== 1'b1 || out_left !== 24'd9) begin
         failures++;
         $display("FAIL buffer_survives valid=%b L=%h required 1/000009", out_valid, out_left);
      end
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   task automatic test_restart();
      int guard;
      enable = 1'b1;
      tick(1);
      checks++;
      if (state !== 3'd1 || cap_rst_n !== 1'b1) begin
         failures++;
         $display("FAIL restart state=%0d cap_rst_n=%b required 1/1", state, cap_rst_n);
      end
      tick(10);
      enable = 1'b0;
      tick(1);
      checks++;
      if (state !== 3'd0 || cap_rst_n !== 1'b0) begin
         failures++;
         $display("FAIL startup_abort state=%0d cap_rst_n=%b required 0/0", state, cap_rst_n);
      end
      enable = 1'b1;
      tick(1);
      mic_frame(1, 1'b0, 1'b0);
      mic_frame(2, 1'b0, 1'b0);
      checks++;
      if (state !== 3'd3) begin
         failures++;
         $display("FAIL rerun state=%0d required=3", state);
      end
      enable = 1'b0;
      tick(1);
      enable = 1'b1;
      guard = 0;
      while (state === 3'd4 && guard < 300) begin
         tick(1);
         guard++;
      end
      checks++;
      if (state !== 3'd0) begin
         failures++;
         $display("FAIL stop_not_aborted state=%0d after=%0d required 0", state, guard);
      end
      tick(1);
      checks++;
      if (state !== 3'd1) begin
         failures++;
         $display("FAIL idle_restart state=%0d required=1", state);
      end
   endtask

   task automatic test_async_reset();
      mic_frame(1, 1'b0, 1'b0);
      mic_frame(2, 1'b0, 1'b0);
      mic_frame(3, 1'b0, 1'b0);
      mic_frame(4, 1'b0, 1'b0);
      checks++;
      if (state !== 3'd3 || out_valid !== 1'b1 || overflow !== 1'b1 || cap_rst_n !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset state=%0d valid=%b ovf=%b cap_rst_n=%b required 3/1/1/1", state, out_valid, overflow, cap_rst_n);
      end
      tick(20);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({sck, ws, cap_rst_n, out_valid, overflow} !== 5'b0 || state !== 3'd0 ||
          out_left !== '0 || out_right !== '0 || frame_cnt !== '0) begin
         failures++;
         $display("FAIL async_reset sck=%b ws=%b cap_rst_n=%b valid=%b ovf=%b state=%0d L=%h R=%h cnt=%0d required all 0",
                  sck, ws, cap_rst_n, out_valid, overflow, state, out_left, out_right, frame_cnt);
      end
      enable = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   initial begin
      test_reset();
      test_startup();
      test_discard_run();
      test_backpressure();
      test_simultaneous();
      test_stop();
      test_restart();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
